vsmac_stream: RTL and testbench

//   Streaming vector-by-scalar multiply-accumulate engine: LANES parallel MACs share one scalar

---
 rtl/vsmac_stream.sv | 152 +++++++++++++++
 tb/tb_vsmac_stream.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/vsmac_stream.sv
// Streaming vector-by-scalar multiply-accumulate engine with handshaked input/output,
// runtime-programmed job length, and per-lane rescale plus saturation to OUT_WIDTH.
module vsmac_stream #(
  parameter int LANES     = 6,
  parameter int IN_WIDTH  = 8,
  parameter int ACC_WIDTH = 24,
  parameter int OUT_WIDTH = 8,
  parameter int MAX_ACC   = 16,
  localparam int CNT_W    = $clog2(MAX_ACC + 1),
  localparam int SH_W     = $clog2(ACC_WIDTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [CNT_W-1:0]             acc_len,
  input  logic [SH_W-1:0]              shift,
  input  logic                         signed_mode,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES*IN_WIDTH-1:0]    a,
  input  logic [IN_WIDTH-1:0]          b,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*OUT_WIDTH-1:0]   out,
  output logic                         busy,
  output logic                         done
);

  localparam int PROD_W = 2 * IN_WIDTH + 2;

  if (ACC_WIDTH < 2 * IN_WIDTH + CNT_W) begin : g_bad_acc_width
    $error("vsmac_stream: ACC_WIDTH too small for IN_WIDTH/MAX_ACC");
  end

  localparam logic signed [ACC_WIDTH-1:0] SMAX = ACC_WIDTH'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SMIN = -ACC_WIDTH'(1 << (OUT_WIDTH - 1));
  localparam logic [ACC_WIDTH-1:0]        UMAX = ACC_WIDTH'((1 << OUT_WIDTH) - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_OUTPUT = 2'd2
  } state_t;

  state_t                         r_state, w_state_next;
  logic [CNT_W-1:0]               r_len;
  logic [SH_W-1:0]                r_shift;
  logic                           r_signed;
  logic [CNT_W-1:0]               r_cnt;
  logic signed [ACC_WIDTH-1:0]    r_acc [LANES];
  logic [LANES*OUT_WIDTH-1:0]     r_out;

  logic signed [ACC_WIDTH-1:0]    w_sum [LANES];
  logic [LANES*OUT_WIDTH-1:0]     w_out_next;
  logic signed [IN_WIDTH:0]       w_ax, w_bx;
  logic signed [PROD_W-1:0]       w_prod;
  logic [CNT_W-1:0]               w_len_in;
  logic                           w_last;
  logic                           w_beat;

  // Shift then clamp; in unsigned mode the sum is non-negative so only the top bound matters.
  function automatic logic [OUT_WIDTH-1:0] requant(input logic signed [ACC_WIDTH-1:0] acc,
                                                   input logic [SH_W-1:0] sh,
                                                   input logic sgn);
    logic signed [ACC_WIDTH-1:0] r;
    if (sgn) begin
      r = acc >>> sh;
      if (r > SMAX)      return SMAX[OUT_WIDTH-1:0];
      else if (r < SMIN) return SMIN[OUT_WIDTH-1:0];
      else               return r[OUT_WIDTH-1:0];
    end else begin
      r = acc >> sh;
      if ($unsigned(r) > UMAX) return UMAX[OUT_WIDTH-1:0];
      else                     return r[OUT_WIDTH-1:0];
    end
  endfunction

  assign w_len_in = (acc_len > CNT_W'(MAX_ACC)) ? CNT_W'(MAX_ACC) : acc_len;
  assign w_beat   = (r_state == S_ACCUM) && in_valid;
  assign w_last   = (r_cnt + CNT_W'(1)) == r_len;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    w_ax       = '0;
    w_bx       = r_signed ? {b[IN_WIDTH-1], b} : {1'b0, b};
    w_prod     = '0;
    w_out_next = '0;
    for (int i = 0; i < LANES; i++) begin
      w_ax     = r_signed ? {a[i*IN_WIDTH + IN_WIDTH - 1], a[i*IN_WIDTH +: IN_WIDTH]}
                          : {1'b0, a[i*IN_WIDTH +: IN_WIDTH]};
      w_prod   = PROD_W'(w_ax) * PROD_W'(w_bx);
      w_sum[i] = r_acc[i] + ACC_WIDTH'(w_prod);
      w_out_next[i*OUT_WIDTH +: OUT_WIDTH] = requant(w_sum[i], r_shift, r_signed);
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    done         = 1'b0;
    busy         = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = (w_len_in == '0) ? S_OUTPUT : S_ACCUM;
      end
      S_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && w_last) w_state_next = S_OUTPUT;
      end
      S_OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          done         = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_len    <= '0;
      r_shift  <= '0;
      r_signed <= 1'b0;
      r_cnt    <= '0;
      r_out    <= '0;
      // NOTE: the accumulator array is reset explicitly so an aborted job leaves no residue.
      for (int i = 0; i < LANES; i++) r_acc[i] <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_IDLE && start) begin
        r_len    <= w_len_in;
        r_shift  <= shift;
        r_signed <= signed_mode;
        r_cnt    <= '0;
        for (int i = 0; i < LANES; i++) r_acc[i] <= '0;
        if (w_len_in == '0) r_out <= '0;
      end else if (w_beat) begin
        r_cnt <= r_cnt + CNT_W'(1);
        for (int i = 0; i < LANES; i++) r_acc[i] <= w_sum[i];
        if (w_last) r_out <= w_out_next;
      end
    end
  end

  assign out = r_out;

endmodule

// File: tb/tb_vsmac_stream.sv
// Directed self-checking bench for vsmac_stream: hand-computed results for unsigned,
// signed saturation, rescale, stalls/backpressure, zero-length jobs and mid-job reset.
module tb_vsmac_stream;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  acc_len;
  logic [4:0]  shift;
  logic        signed_mode;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] out;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  vsmac_stream dut (
    .clk(clk), .reset(reset), .start(start), .acc_len(acc_len), .shift(shift),
    .signed_mode(signed_mode), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] rep(input logic [7:0] v);
    return {6{v}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [4:0] len, input logic [4:0] sh, input logic sgn);
    start = 1'b1; acc_len = len; shift = sh; signed_mode = sgn;
    tick();
    start = 1'b0; acc_len = 5'd0; shift = 5'd0; signed_mode = 1'b0;
  endtask

  task automatic beat(input logic [47:0] av, input logic [7:0] bv);
    in_valid = 1'b1; a = av; b = bv;
    tick();
    in_valid = 1'b0; a = '0; b = '0;
  endtask

  task automatic handshake(input string tag, input logic with_start);
    out_ready = 1'b1;
    start     = with_start;
    acc_len   = 5'd1;
    #1;
    check({tag, "_done_pulse"}, done, 1'b1);
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    acc_len   = 5'd0;
    #1;
    check({tag, "_valid_drop"}, out_valid, 1'b0);
    check({tag, "_done_low"}, done, 1'b0);
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; acc_len = '0; shift = '0; signed_mode = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0;
    tick(); tick();
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_out", out, 48'h0);
    reset = 1'b0;
    tick();

    // 1: unsigned, 2*(1+2+3) = 12 per lane
    start_job(5'd3, 5'd0, 1'b0);
    check("t1_busy", busy, 1'b1);
    check("t1_in_ready", in_ready, 1'b1);
    beat(rep(8'd2), 8'd1);
    beat(rep(8'd2), 8'd2);
    check("t1_no_valid_early", out_valid, 1'b0);
    beat(rep(8'd2), 8'd3);
    check("t1_valid_latency", out_valid, 1'b1);
    check("t1_in_ready_low", in_ready, 1'b0);
    check("t1_out", out, rep(8'd12));
    handshake("t1", 1'b0);

    // 2: signed saturation both directions
    start_job(5'd4, 5'd0, 1'b1);
    repeat (4) beat(rep(8'h7f), 8'h7f);
    check("t2_pos_sat", out, rep(8'h7f));
    handshake("t2p", 1'b0);
    start_job(5'd4, 5'd0, 1'b1);
    repeat (4) beat(rep(8'h80), 8'h7f);
    check("t2_neg_sat", out, rep(8'h80));
    handshake("t2n", 1'b0);

    // 3: rescale; 80000>>4 = 5000 -> 255, and signed -7>>>2 = -2, 14>>>2 = 3
    start_job(5'd2, 5'd4, 1'b0);
    beat({40'h0, 8'd200}, 8'd200);
    beat({40'h0, 8'd200}, 8'd200);
    check("t3_unsigned_sat", out, {40'h0, 8'hff});
    handshake("t3u", 1'b0);
    start_job(5'd2, 5'd2, 1'b1);
    beat({32'h0, 8'h02, 8'hff}, 8'd3);
    beat({32'h0, 8'h02, 8'hff}, 8'd4);
    check("t3_signed_shift", out, {32'h0, 8'h03, 8'hfe});
    handshake("t3s", 1'b0);

    // 4: stalls and backpressure; lane i = (i+1)*60 >> 1
    start_job(5'd3, 5'd1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(1, 3)) begin
        tick();
        check("t4_stall_ready", in_ready, 1'b1);
        check("t4_stall_no_valid", out_valid, 1'b0);
      end
      beat({8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 8'(10 * (k + 1)));
    end
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; a = rep(8'hff); b = 8'hff;
      #1;
      check("t4_bp_valid", out_valid, 1'b1);
      check("t4_bp_no_done", done, 1'b0);
      check("t4_bp_in_ready", in_ready, 1'b0);
      check("t4_bp_out", out, {8'd180, 8'd150, 8'd120, 8'd90, 8'd60, 8'd30});
      tick();
    end
    in_valid = 1'b0; a = '0; b = '0;
    handshake("t4", 1'b0);
    check("t4_out_kept", out, {8'd180, 8'd150, 8'd120, 8'd90, 8'd60, 8'd30});

    // 5: zero-length job, then start pulsed mid-job and alongside the done handshake
    start_job(5'd0, 5'd0, 1'b0);
    check("t5_zero_valid", out_valid, 1'b1);
    check("t5_zero_out", out, 48'h0);
    handshake("t5z", 1'b0);
    start_job(5'd2, 5'd0, 1'b0);
    beat(rep(8'd1), 8'd5);
    start = 1'b1; acc_len = 5'd1; shift = 5'd3; signed_mode = 1'b1;
    tick();
    start = 1'b0; acc_len = 5'd0; shift = 5'd0; signed_mode = 1'b0;
    check("t5_start_ignored", out_valid, 1'b0);
    beat(rep(8'd1), 8'd5);
    check("t5_out", out, rep(8'd10));
    handshake("t5s", 1'b1);

    // 6: reset mid-job aborts, then a fresh job has no residue
    start_job(5'd4, 5'd0, 1'b0);
    beat(rep(8'd3), 8'd7);
    beat(rep(8'd3), 8'd7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_valid", out_valid, 1'b0);
    check("t6_rst_in_ready", in_ready, 1'b0);
    start_job(5'd2, 5'd0, 1'b0);
    beat(rep(8'd1), 8'd1);
    beat(rep(8'd1), 8'd1);
    check("t6_valid", out_valid, 1'b1);
    check("t6_fresh_out", out, rep(8'd2));
    handshake("t6", 1'b0);

    // acc_len above MAX_ACC clamps to 16 beats: 16*1*1 = 16
    start_job(5'd31, 5'd0, 1'b0);
    repeat (15) beat(rep(8'd1), 8'd1);
    check("t7_not_yet", out_valid, 1'b0);
    beat(rep(8'd1), 8'd1);
    check("t7_clamp_valid", out_valid, 1'b1);
    check("t7_clamp_out", out, rep(8'd16));
    handshake("t7", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
